// File: rtl/ice_i2c_slave_if.sv
// I2C target bus bundle: raw bus pins plus the byte-level data/handshake signals.
// The slave modport is the target's view; master is the view of whatever drives it.
interface ice_i2c_slave_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda;
  logic [7:0] o_data;
  logic       o_valid;
  logic [7:0] i_data;
  logic       o_rd;
  logic       o_busy;

  modport slave (
    input  i_scl, i_sda, i_data,
    output o_sda, o_data, o_valid, o_rd, o_busy
  );

  modport master (
    output i_scl, i_sda, i_data,
    input  o_sda, o_data, o_valid, o_rd, o_busy
  );
endinterface

// File: rtl/ice_i2c_slave.sv
// Oversampled I2C target: synchronizes SCL/SDA into i_clk and runs a byte-level
// read/write state machine with a single fixed 7-bit address.
module ice_i2c_slave #(
  parameter logic [6:0] ADDR = 7'h7F
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  ice_i2c_slave_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR       = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD       = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_q, sda_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Sync chain resets to 1 so a released reset on an idle bus creates no events.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= bus.i_scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= bus.i_sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & ~sda_s2_q & sda_h_q;
  assign stop_det  = scl_s2_q & sda_s2_q & ~sda_h_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    sda_d   = sda_q;
    data_d  = data_q;
    valid_d = 1'b0;
    rd_d    = 1'b0;
    busy_d  = busy_q;

    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2_q};
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (shift_q[6:0] == ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = sda_s2_q;
              end else begin
                state_d = ST_IDLE;
                sda_d   = 1'b1;
                busy_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_d = 1'b0;
              cnt_d = 4'd1;
            end else if (rw_q) begin
              // MSB goes out on the same fall that ends the ACK clock.
              state_d = ST_RD;
              shift_d = {bus.i_data[6:0], 1'b1};
              sda_d   = bus.i_data[7];
              rd_d    = 1'b1;
              cnt_d   = 4'd1;
            end else begin
              state_d = ST_WR;
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
            end
          end
        end
        ST_WR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2_q};
            if (cnt_q == 4'd7) begin
              state_d = ST_WR_ACK;
              data_d  = {shift_q[6:0], sda_s2_q};
              valid_d = 1'b1;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_d = 1'b0;
              cnt_d = 4'd1;
            end else begin
              state_d = ST_WR;
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
            end
          end
        end
        ST_RD: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = ST_RD_ACK;
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
            end else begin
              sda_d   = shift_q[7];
              shift_d = {shift_q[6:0], 1'b1};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          // cnt_q==1 marks a master ACK seen on the 9th rise; reload on the next fall.
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_s2_q) begin
              state_d = ST_IDLE;
              sda_d   = 1'b1;
              busy_d  = 1'b0;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = ST_RD;
            shift_d = {bus.i_data[6:0], 1'b1};
            sda_d   = bus.i_data[7];
            rd_d    = 1'b1;
            cnt_d   = 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 8'h00;
      rw_q    <= 1'b0;
      sda_q   <= 1'b1;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      sda_q   <= sda_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_sda   = sda_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_rd    = rd_q;
  assign bus.o_busy  = busy_q;

endmodule
